// File: rtl/bram_sdp_arbiter_if.sv
// Client and BRAM signal bundle for bram_sdp_arbiter.
// slave  : the arbiter (receives client requests, drives BRAM pins).
// master : the surrounding environment (clients plus the BRAM itself).
interface bram_sdp_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    // write clients
    logic          wr_req0, wr_req1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [DW-1:0] wr_data0, wr_data1;
    logic          wr_gnt0, wr_gnt1;
    // read clients
    logic          rd_req0, rd_req1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic          rd_gnt0, rd_gnt1;
    logic [DW-1:0] rd_data;
    logic          rd_valid0, rd_valid1;
    // BRAM port A (write) and port B (read)
    logic          ena, wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;

    modport slave (
        input  wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_req0, rd_req1, rd_addr0, rd_addr1, dob,
        output wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1,
        output rd_data, rd_valid0, rd_valid1,
        output ena, wea, addra, dia, enb, addrb
    );

    modport master (
        output wr_req0, wr_req1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_req0, rd_req1, rd_addr0, rd_addr1, dob,
        input  wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1,
        input  rd_data, rd_valid0, rd_valid1,
        input  ena, wea, addra, dia, enb, addrb
    );
endinterface

// File: rtl/bram_sdp_arbiter.sv
// Two-client round-robin arbiter/sequencer for a simple dual-port BRAM.
// Writes go to port A, reads to port B, arbitrated independently.
// Read data returns two cycles after the accept edge, tagged per client.
// Optional macro BRAM_SDP_ARB_FWD_EN: forward same-cycle write data to a
// colliding read; without it collisions are read-first (old data).
module bram_sdp_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic clk,
    input  logic rst_n,
    bram_sdp_arbiter_if.slave bus
);

    // Pointers hold the last granted client; reset to 1 so client 0 wins first.
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    wr_gnt, rd_gnt;
    logic          wr_acc, rd_acc;
    logic          wr_sel, rd_sel;

    // Port A stage registers (drive the BRAM pins directly)
    logic          ena_q;
    logic [AW-1:0] addra_q;
    logic [DW-1:0] dia_q;

    // Port B stage registers plus the tag/valid pipeline.
    // Index 0 = cycle the BRAM is enabled, index 1 = cycle dob is valid.
    logic          enb_q;
    logic [AW-1:0] addrb_q;
    logic [1:0]    vld_pipe_q;
    logic [1:0]    tag_pipe_q;

    // Grants: lone requester wins, otherwise the client not in the pointer.
    always_comb begin
        wr_gnt = '0;
        rd_gnt = '0;
        if (rst_n) begin
            wr_gnt[0] = bus.wr_req0 & (~bus.wr_req1 |  wr_ptr_q);
            wr_gnt[1] = bus.wr_req1 & (~bus.wr_req0 | ~wr_ptr_q);
            rd_gnt[0] = bus.rd_req0 & (~bus.rd_req1 |  rd_ptr_q);
            rd_gnt[1] = bus.rd_req1 & (~bus.rd_req0 | ~rd_ptr_q);
        end
        wr_acc   = |wr_gnt;
        rd_acc   = |rd_gnt;
        wr_sel   = wr_gnt[1];
        rd_sel   = rd_gnt[1];
        wr_ptr_d = wr_acc ? wr_sel : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_sel : rd_ptr_q;
    end

    assign bus.wr_gnt0 = wr_gnt[0];
    assign bus.wr_gnt1 = wr_gnt[1];
    assign bus.rd_gnt0 = rd_gnt[0];
    assign bus.rd_gnt1 = rd_gnt[1];

    // Round-robin pointers advance on every accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b1;
            rd_ptr_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Write stage: register the winner; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q   <= 1'b0;
            addra_q <= '0;
            dia_q   <= '0;
        end else begin
            ena_q <= wr_acc;
            if (wr_acc) begin
                addra_q <= wr_sel ? bus.wr_addr1 : bus.wr_addr0;
                dia_q   <= wr_sel ? bus.wr_data1 : bus.wr_data0;
            end
        end
    end

    // Read stage: register the winner and shift its tag down the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_q      <= 1'b0;
            addrb_q    <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            enb_q      <= rd_acc;
            if (rd_acc) addrb_q <= rd_sel ? bus.rd_addr1 : bus.rd_addr0;
            vld_pipe_q <= {vld_pipe_q[0], rd_acc};
            tag_pipe_q <= {tag_pipe_q[0], rd_sel};
        end
    end

    assign bus.ena       = ena_q;
    assign bus.wea       = ena_q;
    assign bus.addra     = addra_q;
    assign bus.dia       = dia_q;
    assign bus.enb       = enb_q;
    assign bus.addrb     = addrb_q;
    assign bus.rd_valid0 = vld_pipe_q[1] & ~tag_pipe_q[1];
    assign bus.rd_valid1 = vld_pipe_q[1] &  tag_pipe_q[1];

`ifdef BRAM_SDP_ARB_FWD_EN
    logic          fwd_hit_q;
    logic [DW-1:0] fwd_data_q;

    // Capture write data when port A and B hit the same address together,
    // so the read returns the new value in place of the read-first dob.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q <= ena_q & enb_q & (addra_q == addrb_q);
            if (ena_q & enb_q & (addra_q == addrb_q)) fwd_data_q <= dia_q;
        end
    end

    assign bus.rd_data = fwd_hit_q ? fwd_data_q : bus.dob;
`else
    assign bus.rd_data = bus.dob;
`endif

endmodule

// File: tb/tb_bram_sdp_arbiter.sv
// Scoreboard bench for bram_sdp_arbiter with a behavioural BRAM.
// The reference model tracks memory contents in transaction order and
// last-grant pointers; the monitor compares grants, BRAM pins and read returns.
module tb_bram_sdp_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_sdp_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bram_sdp_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural simple dual-port BRAM, read-first
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.enb) bus.dob <= mem[bus.addrb];
        if (bus.ena && bus.wea) mem[bus.addra] <= bus.dia;
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic          tag;
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    rd_exp_t       rq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          wlast = 1'b1, rlast = 1'b1;
    logic          pw_v = 1'b0, pr_v = 1'b0;
    logic [AW-1:0] pw_a, pr_a;
    logic [DW-1:0] pw_d;

    always @(negedge clk) begin
        logic ew0, ew1, er0, er1;
        rd_exp_t e;
        if (!rst_n) begin
            chk("rst_ena", 32'(bus.ena), 32'(0));
            chk("rst_enb", 32'(bus.enb), 32'(0));
            chk("rst_rd_valid", 32'({bus.rd_valid1, bus.rd_valid0}), 32'(0));
            chk("rst_gnt", 32'({bus.wr_gnt1, bus.wr_gnt0, bus.rd_gnt1, bus.rd_gnt0}), 32'(0));
            rq.delete();
            pw_v = 1'b0; pr_v = 1'b0;
            wlast = 1'b1; rlast = 1'b1;
        end else begin
            // BRAM pins reflect the transfers accepted on the previous edge
            chk("ena", 32'(bus.ena), 32'(pw_v));
            chk("wea", 32'(bus.wea), 32'(pw_v));
            if (pw_v) begin
                chk("addra", 32'(bus.addra), 32'(pw_a));
                chk("dia", 32'(bus.dia), 32'(pw_d));
            end
            chk("enb", 32'(bus.enb), 32'(pr_v));
            if (pr_v) chk("addrb", 32'(bus.addrb), 32'(pr_a));

            // read returns
            if (bus.rd_valid0 || bus.rd_valid1) begin
                if (rq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL rd_spurious: got rd_valid=%b%b expected none (cycle %0d)",
                             bus.rd_valid1, bus.rd_valid0, cyc);
                end else begin
                    e = rq.pop_front();
                    chk("rd_both", 32'(bus.rd_valid0 & bus.rd_valid1), 32'(0));
                    chk("rd_tag", 32'(bus.rd_valid1), 32'(e.tag));
                    chk("rd_data", 32'(bus.rd_data), 32'(e.data));
                    chk("rd_latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("rd_missing", 32'(cyc), 32'(rq[0].cyc + 1000));
                void'(rq.pop_front());
            end

            // grant model: lone requester wins, else the one not granted last
            ew0 = bus.wr_req0 && (!bus.wr_req1 || wlast == 1'b1);
            ew1 = bus.wr_req1 && (!bus.wr_req0 || wlast == 1'b0);
            er0 = bus.rd_req0 && (!bus.rd_req1 || rlast == 1'b1);
            er1 = bus.rd_req1 && (!bus.rd_req0 || rlast == 1'b0);
            chk("wr_gnt", 32'({bus.wr_gnt1, bus.wr_gnt0}), 32'({ew1, ew0}));
            chk("rd_gnt", 32'({bus.rd_gnt1, bus.rd_gnt0}), 32'({er1, er0}));

            // reads see memory as of before this cycle's write (read-first)
            pr_v = er0 | er1;
            if (pr_v) begin
                pr_a   = er1 ? bus.rd_addr1 : bus.rd_addr0;
                e.tag  = er1;
                e.data = ref_mem[pr_a];
`ifdef BRAM_SDP_ARB_FWD_EN
                if (ew0 | ew1) begin
                    if ((ew1 ? bus.wr_addr1 : bus.wr_addr0) == pr_a)
                        e.data = ew1 ? bus.wr_data1 : bus.wr_data0;
                end
`endif
                e.cyc  = cyc + 2;
                rq.push_back(e);
                rlast  = er1;
            end
            pw_v = ew0 | ew1;
            if (pw_v) begin
                pw_a = ew1 ? bus.wr_addr1 : bus.wr_addr0;
                pw_d = ew1 ? bus.wr_data1 : bus.wr_data0;
                ref_mem[pw_a] = pw_d;
                wlast = ew1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_all();
        bus.wr_req0 = 1'b0; bus.wr_req1 = 1'b0;
        bus.rd_req0 = 1'b0; bus.rd_req1 = 1'b0;
    endtask

    // one random cycle; a request is held until its grant is seen
    task automatic rnd_cycle(input int pct);
        logic gw0, gw1, gr0, gr1;
        @(negedge clk);
        gw0 = bus.wr_gnt0; gw1 = bus.wr_gnt1;
        gr0 = bus.rd_gnt0; gr1 = bus.rd_gnt1;
        tick();
        if (!bus.wr_req0 || gw0) begin
            bus.wr_req0  = ($urandom_range(0, 99) < pct);
            bus.wr_addr0 = AW'($urandom_range(0, 15));
            bus.wr_data0 = DW'($urandom);
        end
        if (!bus.wr_req1 || gw1) begin
            bus.wr_req1  = ($urandom_range(0, 99) < pct);
            bus.wr_addr1 = AW'($urandom_range(0, 15));
            bus.wr_data1 = DW'($urandom);
        end
        if (!bus.rd_req0 || gr0) begin
            bus.rd_req0  = ($urandom_range(0, 99) < pct);
            bus.rd_addr0 = AW'($urandom_range(0, 15));
        end
        if (!bus.rd_req1 || gr1) begin
            bus.rd_req1  = ($urandom_range(0, 99) < pct);
            bus.rd_addr1 = AW'($urandom_range(0, 15));
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        idle_all();
        bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // write contention: alternation 0,1,0,1
        bus.wr_req0 = 1'b1; bus.wr_addr0 = AW'(12'h010); bus.wr_data0 = 16'hAAAA;
        bus.wr_req1 = 1'b1; bus.wr_addr1 = AW'(12'h020); bus.wr_data1 = 16'h5555;
        tick(4);
        idle_all();
        tick(2);

        // write 0x1234 to 0x3FF, then client 1 reads it back
        bus.wr_req0 = 1'b1; bus.wr_addr0 = AW'(12'h3FF); bus.wr_data0 = 16'h1234;
        tick();
        idle_all();
        tick();
        bus.rd_req1 = 1'b1; bus.rd_addr1 = AW'(12'h3FF);
        tick();
        idle_all();
        tick(3);

        // prefill 0..7 then back-to-back reads from both clients
        for (int i = 0; i < 8; i++) begin
            bus.wr_req0 = 1'b1; bus.wr_addr0 = AW'(i); bus.wr_data0 = DW'(16'hC000 + i);
            tick();
        end
        idle_all();
        tick();
        begin
            int i0 = 0, i1 = 0, guard = 0;
            logic g0, g1;
            bus.rd_req0 = 1'b1; bus.rd_addr0 = AW'(0);
            bus.rd_req1 = 1'b1; bus.rd_addr1 = AW'(1);
            while ((i0 < 4 || i1 < 4) && guard < 20) begin
                @(negedge clk);
                g0 = bus.rd_gnt0; g1 = bus.rd_gnt1;
                tick();
                guard++;
                if (g0) begin i0++; bus.rd_addr0 = AW'(2 * i0); bus.rd_req0 = (i0 < 4); end
                if (g1) begin i1++; bus.rd_addr1 = AW'(2 * i1 + 1); bus.rd_req1 = (i1 < 4); end
            end
            chk("b2b_done", 32'(i0 + i1), 32'(8));
        end
        idle_all();
        tick(3);

        // collision: 0x0005 holds 0x00FF, then write 0xBEEF and read together
        bus.wr_req0 = 1'b1; bus.wr_addr0 = AW'(5); bus.wr_data0 = 16'h00FF;
        tick();
        idle_all();
        tick(2);
        bus.wr_req1 = 1'b1; bus.wr_addr1 = AW'(5); bus.wr_data1 = 16'hBEEF;
        bus.rd_req0 = 1'b1; bus.rd_addr0 = AW'(5);
        tick();
        idle_all();
        tick(3);

        // single requester held three cycles
        bus.rd_req0 = 1'b1; bus.rd_addr0 = AW'(12'h3FF);
        tick(3);
        idle_all();
        tick(3);

        // randomized traffic
        for (int n = 0; n < 400; n++) rnd_cycle((n < 200) ? 50 : 90);
        idle_all();
        tick(4);

        // reset with reads in flight, no write pending
        bus.rd_req0 = 1'b1; bus.rd_addr0 = AW'(3);
        tick(2);
        rst_n = 1'b0;
        idle_all();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        // first conflict after reset goes to client 0 on both ports
        bus.wr_req0 = 1'b1; bus.wr_addr0 = AW'(9); bus.wr_data0 = 16'h0909;
        bus.wr_req1 = 1'b1; bus.wr_addr1 = AW'(10); bus.wr_data1 = 16'h0A0A;
        bus.rd_req0 = 1'b1; bus.rd_addr0 = AW'(9);
        bus.rd_req1 = 1'b1; bus.rd_addr1 = AW'(10);
        tick();
        idle_all();
        tick(5);

        chk("scoreboard_empty", 32'(rq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bram_sdp_arbiter.md
Name: bram_sdp_arbiter

Overview:
Two-client arbiter and sequencer for a simple dual-port block RAM (write-only port A, read-only port B, single clock, synchronous read).
- Write requests from two clients are round-robin arbitrated onto port A.
- Read requests from two clients are round-robin arbitrated onto port B, independently of writes.
- Read data is returned to the originating client with a valid pulse.
- Sits between client logic and the BRAM, and owns every BRAM control pin.

Parameters:
AW, 10, address width (BRAM depth 2**AW)
DW, 16, data width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_req0 / wr_req1  in  1  client write request, held until granted
wr_addr0 / wr_addr1  in  AW  write address
wr_data0 / wr_data1  in  DW  write data
wr_gnt0 / wr_gnt1  out  1  combinational write grant; transfer occurs on the edge where req and gnt are both high
rd_req0 / rd_req1  in  1  client read request, held until granted
rd_addr0 / rd_addr1  in  AW  read address
rd_gnt0 / rd_gnt1  out  1  combinational read grant
rd_data  out  DW  read data, shared by both clients
rd_valid0 / rd_valid1  out  1  one-cycle pulse: rd_data belongs to client 0 or 1
ena, wea  out  1  BRAM port A enable and write enable (driven together)
addra  out  AW  BRAM port A address
dia  out  DW  BRAM port A write data
enb  out  1  BRAM port B enable
addrb  out  AW  BRAM port B address
dob  in  DW  BRAM port B read data (valid one edge after enb)

Behaviour:
- Reset (async assert, sync release): ena=wea=enb=0, addra=addrb=0, dia=0, rd_valid0/1=0, read tag pipeline cleared. Both last-grant pointers set to 1, so client 0 wins the first conflict.
- Grants:
  - Combinational from req and pointer; at most one wr_gnt and one rd_gnt high per cycle.
  - Single requester: granted immediately.
  - Both requesting: the client not in the pointer is granted.
  - The pointer updates to the granted client on every accepted transfer, alternating under continuous contention.
  - No grant may issue while rst_n is low.
- Write path: the accepted request in cycle N is registered. In cycle N+1, ena=wea=1 with addra/dia = the granted client's addr/data; the RAM is updated at the end of N+1. With no accept, ena=wea=0 and addra/dia hold their previous values.
- Read path: the accepted request in cycle N is registered. In cycle N+1, enb=1 with addrb = the granted address, and a 1-bit client tag plus valid is shifted into the pipeline. In cycle N+2, rd_data=dob and rd_valid<tag>=1 for exactly one cycle. Fixed latency is 2 cycles from the accept edge.
- Throughput: one write and one read accepted per cycle concurrently; back-to-back reads return in order, one per cycle.
- Same-address collision (write and read to the same address issued to the BRAM in the same cycle): read-first. The read returns the old content unless BRAM_SDP_ARB_FWD_EN is defined.
- Reset mid-operation: in-flight reads are discarded with no rd_valid. A write registered but not yet performed is dropped.
- Address and data widths pass through unchanged; no wrap logic. Addresses are used modulo 2**AW by construction.

Optional Feature:
BRAM_SDP_ARB_FWD_EN
- Defined: write-to-read forwarding. When addra==addrb with ena and enb both high in the same cycle, dia is captured into a forwarding register with a hit flag. In the following cycle rd_data = the forwarded data instead of dob. Latency is unchanged.
- Undefined: no forwarding logic; rd_data=dob always (read-first collision semantics).

Test Plan:
- Reset: assert rst_n=0 mid-stream with a read in flight -> all BRAM enables 0, no rd_valid during or after reset; after release, first conflict grants client 0.
- Write contention: wr_req0 and wr_req1 held high for 4 cycles (addrs 0x010/0x020, data 0xAAAA/0x5555) -> grants alternate 0,1,0,1. ena pulses at 0x010, 0x020, 0x010, 0x020 one cycle after each grant.
- Read latency/tag: write 0x1234 to 0x3FF, then rd_req1 at 0x3FF -> enb/addrb=0x3FF one cycle after grant; rd_valid1=1, rd_valid0=0, rd_data=0x1234 two cycles after grant.
- Back-to-back reads: both clients read continuously from prefilled addresses 0..7 -> one rd_valid per cycle, alternating tags, data in order, no bubbles.
- Collision: 0x0005 holds 0x00FF; write 0xBEEF and read 0x0005 accepted in the same cycle -> rd_data=0x00FF without the macro, 0xBEEF with BRAM_SDP_ARB_FWD_EN.
- Single requester: only rd_req0 held 3 cycles -> rd_gnt0 high all 3 cycles, rd_gnt1 never high.
